truth_sweep: RTL and testbench

Sequential stimulus generator and response checker for 3-input combinational logic blocks under test. It sits directly upstream and downstream of the DUT. It drives the DUT inputs `a`, `b`, `c` through all 8 vectors in ascending order, holds each vector for a settle window, and samples the DUT output `y`. Each sample is compared against a parameterised expected truth table, and the block reports pass/fail, an error count and a per-vector failure map. It replaces hand-written delay-based testbench sequencing with a synthesizable, clocked sweep.

---
 rtl/truth_sweep.sv | 103 ++++++++++
 tb/tb_truth_sweep.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/truth_sweep.sv
// rtl/truth_sweep.sv - clocked 3-input truth-table sweep generator and response checker
// Optional macro TRUTH_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module truth_sweep #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXP_MASK = 8'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_map
);

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_err_cnt;
  logic [7:0] r_fail_map;
  logic       r_pass;

  logic       w_sample;
  logic       w_miss;
  logic       w_last;
  logic [3:0] w_err_nxt;

  assign w_sample  = (r_state == S_RUN) && (r_cnt == LP_SETTLE);
  assign w_miss    = w_sample && (y != EXP_MASK[r_idx]);
  assign w_err_nxt = r_err_cnt + {3'b000, w_miss};

`ifdef TRUTH_SWEEP_STOP_ON_FAIL_EN
  assign w_last = (r_idx == 3'd7) || w_miss;
`else
  assign w_last = (r_idx == 3'd7);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_sample && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Results are only touched when a sweep starts or a vector is sampled,
  // so they hold through DONE and IDLE until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 3'd0;
      r_cnt      <= 4'd0;
      r_err_cnt  <= 4'd0;
      r_fail_map <= 8'h00;
      r_pass     <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_idx      <= 3'd0;
      r_cnt      <= 4'd0;
      r_err_cnt  <= 4'd0;
      r_fail_map <= 8'h00;
      r_pass     <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_sample) begin
        r_cnt     <= 4'd0;
        r_err_cnt <= w_err_nxt;
        if (w_miss) r_fail_map[r_idx] <= 1'b1;
        // The final vector holds on the pins so a stopped sweep shows what failed.
        if (w_last) r_pass <= (w_err_nxt == 4'd0);
        else        r_idx  <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign {a, b, c} = r_idx;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_map  = r_fail_map;

endmodule

// File: tb/tb_truth_sweep.sv
// tb/tb_truth_sweep.sv - randomized self-checking bench for truth_sweep
// Honours TRUTH_SWEEP_STOP_ON_FAIL_EN when computing expected results.
module tb_truth_sweep;

  localparam int         S0  = 2;
  localparam logic [7:0] EXP = 8'h3F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [7:0] tbl0, tbl1;

  logic       a0, b0, c0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [7:0] map0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] map1;
  wire        y0 = tbl0[{a0, b0, c0}];
  wire        y1 = tbl1[{a1, b1, c1}];

  truth_sweep #(.SETTLE(S0), .EXP_MASK(EXP)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_map(map0)
  );

  truth_sweep #(.SETTLE(0), .EXP_MASK(EXP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_map(map1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outcome derived from the table: which vectors differ from EXP,
  // and (in stop mode) only the first of them counts.
  task automatic sweep0(input logic [7:0] tbl);
    logic [7:0] diff, exp_map;
    int lat, exp_err, exp_last, n, f;
    diff = tbl ^ EXP;
`ifdef TRUTH_SWEEP_STOP_ON_FAIL_EN
    f = 8;
    for (int i = 7; i >= 0; i--) if (diff[i]) f = i;
    if (f == 8) begin
      lat = 8 * (S0 + 1); exp_map = 8'h00; exp_err = 0; exp_last = 7;
    end else begin
      lat = (f + 1) * (S0 + 1); exp_map = 8'(1 << f); exp_err = 1; exp_last = f;
    end
`else
    f = 0;
    lat = 8 * (S0 + 1); exp_map = diff; exp_err = $countones(diff); exp_last = 7;
`endif
    tbl0   = tbl;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    chk("busy_e0", busy0, 1);
    chk("vec_e0", {a0, b0, c0}, 0);
    chk("pass_clr", pass0, 0);
    while (!done0 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (!done0) chk("vec", {a0, b0, c0}, n / (S0 + 1));
    end
    chk("latency", n, lat);
    chk("pass", pass0, int'(exp_err == 0));
    chk("err_cnt", err0, exp_err);
    chk("fail_map", map0, exp_map);
    chk("vec_last", {a0, b0, c0}, exp_last);
    chk("busy_done", busy0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done0, 0);
    chk("err_hold", err0, exp_err);
    chk("map_hold", map0, exp_map);
    chk("pass_hold", pass0, int'(exp_err == 0));
  endtask

  initial begin
    int ph, pulses;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    tbl0   = EXP;
    tbl1   = EXP;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_abc", {a0, b0, c0}, 0);
    chk("rst_flags", {busy0, done0, pass0}, 0);
    chk("rst_err", err0, 0);
    chk("rst_map", map0, 0);
    chk("rst1_all", {a1, b1, c1, busy1, done1, pass1, err1, map1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep0(8'h3F);
    sweep0(8'h00);
    sweep0(8'h55);
    for (int r = 0; r < 6; r++) sweep0(8'($urandom));

    // SETTLE=0 instance with start held high: 10-cycle period per sweep.
    start1 = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      @(negedge clk);
      ph = (j - 1) % 10;
      chk("b2b_busy", busy1, int'(ph < 8));
      chk("b2b_done", done1, int'(ph == 8));
      chk("b2b_pass", pass1, int'(ph >= 8));
      if (ph <= 8) chk("b2b_vec", {a1, b1, c1}, (ph < 8) ? ph : 7);
      if (ph >= 8) chk("b2b_err", err1, 0);
    end
    start1 = 1'b0;

    // Asynchronous abort mid-sweep.
    tbl0   = EXP;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_abc", {a0, b0, c0}, 0);
    chk("abort_flags", {busy0, done0, pass0}, 0);
    chk("abort_res", {err0, map0}, 0);
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (done0 || busy0) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    sweep0(8'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
